// File: rtl/sram_read_arbiter.sv
// sram_read_arbiter
// Two requesters share one read-only SRAM port. Each granted read drives the
// SRAM controls for a fixed wait, captures the data bus into the owner's data
// register and gives the owner one acknowledge pulse. Ties are broken
// round-robin so that both ports make progress.

module sram_read_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_data,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_data,
  output logic              busy,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic [DATA_W-1:0] SRAM_DQ
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  // Four bits cover the full legal wait range; the counter is loaded with
  // WAIT_CYCLES-1 so the capture happens on the cycle it reads zero.
  localparam int               CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_next;
  logic               owner_b, owner_b_next;
  logic               last_b, last_b_next;
  logic               sram_ctl_n, sram_ctl_n_next;
  logic [ADDR_W-1:0]  sram_addr_next;
  logic               a_ack_next, b_ack_next;
  logic [DATA_W-1:0]  a_data_next, b_data_next;
  logic               busy_next;
  logic               grant_a, grant_b;

  // Chip, output and byte enables always move together, and the block never writes.
  assign SRAM_CE_N = sram_ctl_n;
  assign SRAM_OE_N = sram_ctl_n;
  assign SRAM_UB_N = sram_ctl_n;
  assign SRAM_LB_N = sram_ctl_n;
  assign SRAM_WE_N = 1'b1;

  // Round-robin tie break: on a tie, the port that did not win last time is granted.
  always_comb begin
    grant_a = a_req && (!b_req || last_b);
    grant_b = b_req && !grant_a;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_next      = state;
    wait_cnt_next   = wait_cnt;
    owner_b_next    = owner_b;
    last_b_next     = last_b;
    sram_ctl_n_next = 1'b1;
    sram_addr_next  = SRAM_ADDR;
    a_ack_next      = 1'b0;
    b_ack_next      = 1'b0;
    a_data_next     = a_data;
    b_data_next     = b_data;
    case (state)
      IDLE: begin
        if (grant_a || grant_b) begin
          sram_addr_next  = grant_a ? a_addr : b_addr;
          owner_b_next    = grant_b;
          last_b_next     = grant_b;
          wait_cnt_next   = CNT_LOAD;
          sram_ctl_n_next = 1'b0;
          state_next      = ACCESS;
        end
      end
      ACCESS: begin
        if (wait_cnt == '0) begin
          if (owner_b) begin
            b_data_next = SRAM_DQ;
            b_ack_next  = 1'b1;
          end else begin
            a_data_next = SRAM_DQ;
            a_ack_next  = 1'b1;
          end
          state_next = DONE;
        end else begin
          wait_cnt_next   = wait_cnt - CNT_W'(1);
          sram_ctl_n_next = 1'b0;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // State and output registers; reset drops everything back to idle at once.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      owner_b    <= 1'b0;
      last_b     <= 1'b1;
      sram_ctl_n <= 1'b1;
      SRAM_ADDR  <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_data     <= '0;
      b_data     <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_cnt_next;
      owner_b    <= owner_b_next;
      last_b     <= last_b_next;
      sram_ctl_n <= sram_ctl_n_next;
      SRAM_ADDR  <= sram_addr_next;
      a_ack      <= a_ack_next;
      b_ack      <= b_ack_next;
      a_data     <= a_data_next;
      b_data     <= b_data_next;
      busy       <= busy_next;
    end
  end

endmodule

// File: tb/tb_sram_read_arbiter.sv
// tb_sram_read_arbiter
// Three arbiter instances (WAIT_CYCLES 2, 1 and 15) are exercised from one
// clock. Each has its own reference model, which predicts grants from the
// arbitration and timing rules, and its own scoreboard/monitor pair.

module tb_sram_read_arbiter;

  localparam int AW    = 20;
  localparam int DW    = 16;
  localparam int NINST = 3;

  typedef struct {
    bit            port_b;
    logic [DW-1:0] data;
    int            ack_edge;
  } exp_t;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   done_flag [NINST];

  // Free-running system clock.
  always #5 clk = ~clk;

  // Memory contents: a few fixed words, everything else a simple hash of the address.
  function automatic logic [DW-1:0] sram_val(input logic [AW-1:0] a);
    case (a)
      20'h00010: return 16'hBEEF;
      20'h00005: return 16'h1111;
      20'h00009: return 16'h2222;
      default:   return (a[15:0] * 16'h9E37) ^ {a[19:16], 12'h5A5};
    endcase
  endfunction

  task automatic check_output(input int w, input string name,
                              input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL W=%0d %s actual=%0h required=%0h at %0t", w, name, actual, required, $time);
    end
  endtask

  for (genvar gi = 0; gi < NINST; gi++) begin : g_inst
    localparam int W     = (gi == 0) ? 2 : ((gi == 1) ? 1 : 15);
    localparam int LIMIT = 3 * (W + 2) + 6;

    logic          rst_n  = 1'b1;
    logic          a_req  = 1'b0;
    logic          b_req  = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [AW-1:0] b_addr = '0;
    logic          a_ack, b_ack, busy;
    logic [DW-1:0] a_data, b_data;
    logic          ce_n, oe_n, we_n, ub_n, lb_n;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq;

    exp_t          exp_q [$];
    int            edge_cnt  = 0;
    int            idle_edge = 0;
    int            g_edge    = 0;
    bit            last_b    = 1'b1;
    bit            g_valid   = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] held_a    = '0;
    logic [DW-1:0] held_b    = '0;

    // The SRAM only drives real data while its output is enabled.
    assign sram_dq = oe_n ? 16'hDEAD : sram_val(sram_addr);

    sram_read_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)
    ) dut (
      .Clk(clk), .Reset_n(rst_n),
      .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_data(a_data),
      .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_data(b_data),
      .busy(busy),
      .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
      .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
      .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq)
    );

    // Reference model: a request seen at a free edge is granted, its ack is due
    // W edges later and the arbiter is free again W+2 edges after the grant.
    always @(posedge clk) begin
      bit   ga, gb;
      exp_t e;
      edge_cnt++;
      if (!rst_n) begin
        exp_q.delete();
        idle_edge = edge_cnt + 1;
        last_b    = 1'b1;
        g_valid   = 1'b0;
        last_addr = '0;
      end else if (edge_cnt >= idle_edge) begin
        ga = a_req && (!b_req || last_b);
        gb = b_req && !ga;
        if (ga || gb) begin
          last_addr  = ga ? a_addr : b_addr;
          e.port_b   = gb;
          e.data     = sram_val(last_addr);
          e.ack_edge = edge_cnt + W;
          exp_q.push_back(e);
          g_edge    = edge_cnt;
          g_valid   = 1'b1;
          last_b    = gb;
          idle_edge = edge_cnt + W + 2;
        end
      end
    end

    // Monitor: mid-cycle, pop any due expectation and compare every output.
    always @(negedge clk) begin
      exp_t e;
      bit   ea, eb, acc, bsy;
      ea = 1'b0;
      eb = 1'b0;
      if (!rst_n) begin
        held_a = '0;
        held_b = '0;
      end else if (exp_q.size() > 0 && exp_q[0].ack_edge == edge_cnt) begin
        e  = exp_q.pop_front();
        ea = !e.port_b;
        eb = e.port_b;
        if (e.port_b) held_b = e.data;
        else          held_a = e.data;
      end
      acc = rst_n && g_valid && (edge_cnt >= g_edge) && (edge_cnt < g_edge + W);
      bsy = rst_n && g_valid && (edge_cnt >= g_edge) && (edge_cnt <= g_edge + W);
      check_output(W, "a_ack", 32'(a_ack), 32'(ea));
      check_output(W, "b_ack", 32'(b_ack), 32'(eb));
      check_output(W, "a_data", 32'(a_data), 32'(held_a));
      check_output(W, "b_data", 32'(b_data), 32'(held_b));
      check_output(W, "ctl_n", 32'({ce_n, oe_n, ub_n, lb_n}), acc ? 32'h0 : 32'hF);
      check_output(W, "we_n", 32'(we_n), 32'd1);
      check_output(W, "busy", 32'(busy), 32'(bsy));
      check_output(W, "sram_addr", 32'(sram_addr), rst_n ? 32'(last_addr) : 32'd0);
    end

    task automatic idle_cycles(input int n);
      repeat (n) begin
        @(posedge clk);
        #2;
      end
    endtask

    task automatic reset_dut();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      idle_cycles(2);
      rst_n = 1'b1;
    endtask

    // Raise one request and hold it until its ack; optionally drop it or pulse reset mid-way.
    task automatic apply_stimulus(input bit pb, input logic [AW-1:0] adr,
                                  input int drop_at, input int rst_at, input bit keep);
      int n;
      bit got;
      if (pb) begin b_addr = adr; b_req = 1'b1; end
      else    begin a_addr = adr; a_req = 1'b1; end
      n   = 0;
      got = 1'b0;
      while (!got && n < LIMIT) begin
        @(posedge clk);
        #2;
        n++;
        if (n == drop_at) begin
          if (pb) b_req = 1'b0;
          else    a_req = 1'b0;
        end
        if (n == rst_at) begin
          rst_n = 1'b0;
          idle_cycles(2);
          rst_n = 1'b1;
        end
        got = pb ? b_ack : a_ack;
      end
      check_output(W, pb ? "b_ack_seen" : "a_ack_seen", 32'(got), 32'd1);
      if (!keep) begin
        if (pb) b_req = 1'b0;
        else    a_req = 1'b0;
      end
    endtask

    task automatic rand_port(input bit pb);
      logic [AW-1:0] adr;
      bit            held;
      held = 1'b0;
      adr  = '0;
      for (int i = 0; i < 25; i++) begin
        if (!held) begin
          idle_cycles($urandom_range(0, 3));
          adr = AW'($urandom);
          if ($urandom_range(0, 4) == 0) adr = 20'h00010;
        end
        held = ($urandom_range(0, 1) == 1);
        apply_stimulus(pb, adr, 0, 0, held);
      end
      if (pb) b_req = 1'b0;
      else    a_req = 1'b0;
    endtask

    // Directed phases first, then both ports randomly contending.
    initial begin
      int acks, n;
      reset_dut();
      apply_stimulus(1'b0, 20'h00010, 0, 0, 1'b0);
      idle_cycles(W + 4);

      reset_dut();
      a_addr = 20'h00005;
      b_addr = 20'h00009;
      a_req  = 1'b1;
      b_req  = 1'b1;
      acks   = 0;
      n      = 0;
      while (acks < 6 && n < 6 * (W + 2) + 10) begin
        @(posedge clk);
        #2;
        n++;
        if (a_ack || b_ack) begin
          check_output(W, "grant_order", 32'(b_ack), 32'(acks % 2));
          acks++;
        end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      check_output(W, "six_grants", 32'(acks), 32'd6);
      idle_cycles(W + 4);

      apply_stimulus(1'b1, 20'h00ABC, 1, 0, 1'b0);
      idle_cycles(W + 4);

      apply_stimulus(1'b0, 20'h00123, 0, 1, 1'b0);
      idle_cycles(W + 4);

      fork
        rand_port(1'b0);
        rand_port(1'b1);
      join
      idle_cycles(W + 6);
      check_output(W, "queue_empty", 32'(exp_q.size()), 32'd0);
      done_flag[gi] = 1'b1;
    end
  end

  // Wait (bounded) for every instance to finish, then report.
  initial begin
    int t;
    t = 0;
    while (!(done_flag[0] && done_flag[1] && done_flag[2]) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    check_output(0, "all_done", 32'(done_flag[0] && done_flag[1] && done_flag[2]), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
